// File: rtl/flp_align_seq.sv
// Multi-cycle right-shift-and-jam aligner: shifts a mantissa by up to STEP bits
// per cycle, ORing every bit shifted out into the result LSB (sticky).
module flp_align_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = 8,
  parameter int STEP  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_mant,
  input  logic [SHW-1:0]   in_shamt,
  output logic             out_valid,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_mant,
  output logic             busy
);

  localparam int RW = $clog2(WIDTH);

  // Handshake: a transfer happens on a rising edge where valid & ready are both
  // high; valid is held with stable data until then, ready may depend on the
  // consumer's ready (in_rdy follows out_rdy combinationally in DONE).

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] data, data_nx;
  logic [RW-1:0]    rem, rem_nx;
  logic [RW-1:0]    rem_in;
  logic [RW-1:0]    step_s;
  logic [WIDTH-1:0] ones;
  logic [WIDTH-1:0] jam_mask;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] data_step;
  logic             accept;

  assign in_rdy    = (state == IDLE) | ((state == DONE) & out_rdy);
  assign accept    = in_valid & in_rdy;
  assign out_valid = (state == DONE);
  assign out_mant  = out_valid ? data : '0;
  assign busy      = (state != IDLE);

  // Shifting by WIDTH-1 already jams everything but the MSB into bit 0, so any
  // larger amount gives the same result.
  always_comb begin
    if (in_shamt >= SHW'(WIDTH - 1)) rem_in = RW'(WIDTH - 1);
    else                             rem_in = RW'(in_shamt);
  end

  assign step_s    = (rem > RW'(STEP)) ? RW'(STEP) : rem;
  assign ones      = '1;
  assign jam_mask  = ~((ones << step_s) << 1);
  assign shifted   = data >> step_s;
  assign data_step = {shifted[WIDTH-1:1], |(data & jam_mask)};

  always_comb begin
    state_nx = state;
    data_nx  = data;
    rem_nx   = rem;
    case (state)
      IDLE: ;
      SHIFT: begin
        data_nx = data_step;
        rem_nx  = rem - step_s;
        if (rem == step_s) state_nx = DONE;
      end
      DONE: if (out_rdy) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // A new operand overrides the IDLE/DONE decision above.
    if (accept) begin
      data_nx  = in_mant;
      rem_nx   = rem_in;
      state_nx = (rem_in == '0) ? DONE : SHIFT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      data  <= '0;
      rem   <= '0;
    end else begin
      state <= state_nx;
      data  <= data_nx;
      rem   <= rem_nx;
    end
  end

endmodule

// File: tb/tb_flp_align_seq.sv
// Bench for flp_align_seq: directed vectors plus a randomised run, with an
// expected-value queue drained by an independent output monitor.
module tb_flp_align_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_rdy;
  logic [31:0] in_mant;
  logic [7:0]  in_shamt;
  logic        out_valid;
  logic        out_rdy;
  logic [31:0] out_mant;
  logic        busy;

  logic        rdy_dir;
  logic        rnd_mode;
  logic        rnd_bit = 1'b1;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  flp_align_seq #(.WIDTH(32), .SHW(8), .STEP(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_rdy(in_rdy), .in_mant(in_mant), .in_shamt(in_shamt),
    .out_valid(out_valid), .out_rdy(out_rdy), .out_mant(out_mant), .busy(busy)
  );

  // clock / consumer-ready generation
  always #5 clk = ~clk;
  always @(posedge clk) begin
    #2;
    rnd_bit = 1'($urandom_range(0, 1));
  end
  assign out_rdy = rnd_mode ? rnd_bit : rdy_dir;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endfunction

  // golden single-step shift-right-and-jam
  function automatic logic [31:0] jam(logic [31:0] m, int sh);
    logic [31:0] mask;
    if (sh >= 32) return {31'b0, |m};
    if (sh == 0) return m;
    mask = (32'h1 << sh) - 32'h1;
    return (m >> sh) | {31'b0, |(m & mask)};
  endfunction

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_rdy) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got %h expected none at %0t", out_mant, $time);
        end else begin
          chk("out_mant", out_mant, exp_q.pop_front());
        end
      end else if (!out_valid) begin
        chk("out_mant_zero_when_invalid", out_mant, 32'h0);
      end
    end
  end

  // driver tasks: called in the phase just after a rising edge
  task automatic send(input logic [31:0] m, input logic [7:0] sh, input logic [31:0] e);
    int n = 0;
    in_valid = 1'b1;
    in_mant  = m;
    in_shamt = sh;
    @(negedge clk);
    while (!in_rdy && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_rdy) begin
      chk("accept_timeout", 32'(in_rdy), 32'h1);
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_mant  = $urandom;
    in_shamt = 8'($urandom_range(0, 255));
  endtask

  task automatic wait_valid(output int lat);
    int cnt = 0;
    while (!out_valid && cnt < 40) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    if (!out_valid) chk("out_valid_timeout", 32'(out_valid), 32'h1);
    lat = cnt + 1;
  endtask

  typedef struct {
    logic [31:0] m;
    logic [7:0]  sh;
    logic [31:0] e;
    int          lat;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int lat;
    int n;
    vecs[0]  = '{32'hDEADBEEF, 8'd0,   32'hDEADBEEF, 1};
    vecs[1]  = '{32'h80000010, 8'd5,   32'h04000001, 3};
    vecs[2]  = '{32'h80000000, 8'd5,   32'h04000000, 3};
    vecs[3]  = '{32'h00000001, 8'd200, 32'h00000001, 9};
    vecs[4]  = '{32'h00000000, 8'd200, 32'h00000000, 9};
    vecs[5]  = '{32'hFFFFFFFF, 8'd31,  32'h00000001, 9};
    vecs[6]  = '{32'h00000100, 8'd8,   32'h00000001, 3};
    vecs[7]  = '{32'h00000100, 8'd9,   32'h00000001, 4};
    vecs[8]  = '{32'h00000300, 8'd8,   32'h00000003, 3};
    vecs[9]  = '{32'h40000000, 8'd31,  32'h00000001, 9};
    vecs[10] = '{32'hF0000000, 8'd32,  32'h00000001, 9};
    vecs[11] = '{32'hA0000000, 8'd3,   32'h14000000, 2};
    vecs[12] = '{32'h12345678, 8'd4,   32'h01234567, 2};

    rst = 1'b1; in_valid = 1'b0; in_mant = '0; in_shamt = '0;
    rdy_dir = 1'b1; rnd_mode = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'h0);
    chk("reset_out_mant", out_mant, 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_in_rdy", 32'(in_rdy), 32'h1);
    @(posedge clk);
    #1;

    // directed vectors with latency
    foreach (vecs[i]) begin
      send(vecs[i].m, vecs[i].sh, vecs[i].e);
      wait_valid(lat);
      chk($sformatf("latency_%0d", i), 32'(lat), 32'(vecs[i].lat));
    end
    @(posedge clk);
    #1;

    // backpressure: hold the result, then release and accept in the same cycle
    rdy_dir = 1'b0;
    send(32'h11223344, 8'd0, 32'h11223344);
    in_valid = 1'b1; in_mant = 32'h55667788; in_shamt = 8'd0;
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_rdy", 32'(in_rdy), 32'h0);
      chk("bp_out_valid", 32'(out_valid), 32'h1);
      chk("bp_out_mant_held", out_mant, 32'h11223344);
    end
    @(posedge clk);
    #1 rdy_dir = 1'b1;
    @(negedge clk);
    chk("bp_release_in_rdy", 32'(in_rdy), 32'h1);
    exp_q.push_back(32'h55667788);
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("bp_no_bubble_valid", 32'(out_valid), 32'h1);
    chk("bp_no_bubble_mant", out_mant, 32'h55667788);
    @(posedge clk);
    #1;

    // reset in the middle of SHIFT discards the operand
    send(32'hFFFFFFFF, 8'd20, 32'h00000FFF);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midshift_rst_out_valid", 32'(out_valid), 32'h0);
    chk("midshift_rst_busy", 32'(busy), 32'h0);
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    send(32'h00000003, 8'd1, 32'h00000001);
    wait_valid(lat);
    chk("post_rst_latency", 32'(lat), 32'd2);
    @(posedge clk);
    #1;

    // randomised traffic with random gaps and consumer stalls
    rnd_mode = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] m;
      int sh;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      m  = $urandom;
      sh = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 40));
      send(m, 8'(sh), jam(m, sh));
    end
    rnd_mode = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    chk("drain_queue_empty", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
